// File: rtl/ycr_dmem_router.sv
// ycr_dmem_router: steers core data-memory requests to the local TCM/timer
// port (port 0, single beat) or the wishbone data bridge (port 1, bursts),
// remembers the port of every accepted request in issue order and returns
// each response to the core from whichever port is currently at the head.
module ycr_dmem_router #(
    parameter logic [31:0] P0_ADDR_MASK    = 32'hFFFF_C000,
    parameter logic [31:0] P0_ADDR_PATTERN = 32'h0C48_0000,
    parameter int          MAX_OUTST       = 2,
    parameter int          BL_W            = 10
) (
    input  logic            core_clk,
    input  logic            core_rst_n,
    // core LSU side
    input  logic            dmem_req,
    output logic            dmem_req_ack,
    input  logic            dmem_cmd,
    input  logic [1:0]      dmem_width,
    input  logic [31:0]     dmem_addr,
    input  logic [BL_W-1:0] dmem_bl,
    input  logic [31:0]     dmem_wdata,
    output logic [31:0]     dmem_rdata,
    output logic [1:0]      dmem_resp,
    // port 0: TCM / timer, single beat
    output logic            p0_req,
    input  logic            p0_req_ack,
    output logic            p0_cmd,
    output logic [1:0]      p0_width,
    output logic [31:0]     p0_addr,
    output logic [BL_W-1:0] p0_bl,
    output logic [31:0]     p0_wdata,
    input  logic [31:0]     p0_rdata,
    input  logic [1:0]      p0_resp,
    // port 1: wishbone data bridge, burst capable
    output logic            p1_req,
    input  logic            p1_req_ack,
    output logic            p1_cmd,
    output logic [1:0]      p1_width,
    output logic [31:0]     p1_addr,
    output logic [BL_W-1:0] p1_bl,
    output logic [31:0]     p1_wdata,
    input  logic [31:0]     p1_rdata,
    input  logic [1:0]      p1_resp,
    // sticky error flag
    output logic            spurious_resp
);

    localparam logic [1:0] RESP_NOTRDY  = 2'b00;
    localparam logic [1:0] RESP_RDY_OK  = 2'b01;
    localparam logic [1:0] RESP_RDY_ER  = 2'b10;
    localparam logic [1:0] RESP_RDY_LOK = 2'b11;

    localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int CW = $clog2(MAX_OUTST + 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FWD  = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_sel;        // port of the request being forwarded
    logic                 r_last;       // port of the most recently pushed entry
    logic [MAX_OUTST-1:0] r_fifo;       // port id per outstanding transaction
    logic [PW-1:0]        r_wr_ptr;
    logic [PW-1:0]        r_rd_ptr;
    logic [CW-1:0]        r_cnt;
    logic                 r_spur;

    logic                 w_tgt;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_grant;
    logic                 w_start;
    logic                 w_port_ack;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_head;
    logic [1:0]           w_head_resp;
    logic [31:0]          w_head_rdata;
    logic                 w_spur_p0;
    logic                 w_spur_p1;

    function automatic logic [PW-1:0] f_ptr_inc(input logic [PW-1:0] ptr);
        return (ptr == PW'(MAX_OUTST - 1)) ? '0 : ptr + 1'b1;
    endfunction

    // Address decode and issue gating. Requests to a different port are held
    // off until everything in flight has drained, so responses never need
    // reordering between the two targets.
    assign w_tgt   = ((dmem_addr & P0_ADDR_MASK) == P0_ADDR_PATTERN) ? 1'b0 : 1'b1;
    assign w_empty = (r_cnt == '0);
    assign w_full  = (r_cnt == CW'(MAX_OUTST));
    assign w_grant = !w_full && (w_empty || (w_tgt == r_last));
    assign w_start = (r_state == ST_IDLE) && dmem_req && w_grant;

    assign w_port_ack = r_sel ? p1_req_ack : p0_req_ack;

    // Request fields go straight through; only the req strobe is steered.
    assign p0_cmd   = dmem_cmd;
    assign p0_width = dmem_width;
    assign p0_addr  = dmem_addr;
    assign p0_bl    = BL_W'(1);
    assign p0_wdata = dmem_wdata;
    assign p1_cmd   = dmem_cmd;
    assign p1_width = dmem_width;
    assign p1_addr  = dmem_addr;
    assign p1_bl    = dmem_bl;
    assign p1_wdata = dmem_wdata;

    // FSM state and selected-port register.
    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            r_state <= ST_IDLE;
            r_sel   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) r_sel <= w_tgt;
        end
    end

    // FSM next state, port request strobes and core ack.
    always_comb begin
        w_state_nxt  = r_state;
        p0_req       = 1'b0;
        p1_req       = 1'b0;
        dmem_req_ack = 1'b0;
        w_push       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) w_state_nxt = ST_FWD;
            end
            ST_FWD: begin
                p0_req = !r_sel;
                p1_req = r_sel;
                if (w_port_ack) begin
                    dmem_req_ack = 1'b1;
                    w_push       = 1'b1;
                    w_state_nxt  = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Head-of-queue response selection; non-final burst beats (OK on port 1)
    // are forwarded without retiring the entry.
    assign w_head       = r_fifo[r_rd_ptr];
    assign w_head_resp  = w_head ? p1_resp  : p0_resp;
    assign w_head_rdata = w_head ? p1_rdata : p0_rdata;
    assign dmem_resp    = w_empty ? RESP_NOTRDY : w_head_resp;
    assign dmem_rdata   = w_empty ? 32'h0 : w_head_rdata;

    assign w_pop = !w_empty &&
                   ((w_head_resp == RESP_RDY_ER) || (w_head_resp == RESP_RDY_LOK) ||
                    (!w_head && (w_head_resp == RESP_RDY_OK)));

    // A response from a port that does not own the head entry has nowhere to go.
    assign w_spur_p0 = (p0_resp != RESP_NOTRDY) && (w_empty || w_head);
    assign w_spur_p1 = (p1_resp != RESP_NOTRDY) && (w_empty || !w_head);

    // Order FIFO: push on port accept, pop on final response.
    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            r_fifo   <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_last   <= 1'b0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= r_sel;
                r_wr_ptr         <= f_ptr_inc(r_wr_ptr);
                r_last           <= r_sel;
            end
            if (w_pop) r_rd_ptr <= f_ptr_inc(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Sticky spurious-response flag, cleared only by reset.
    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n)                   r_spur <= 1'b0;
        else if (w_spur_p0 || w_spur_p1)   r_spur <= 1'b1;
    end

    assign spurious_resp = r_spur;

endmodule

// File: tb/tb_ycr_dmem_router.sv
// Scoreboard bench for ycr_dmem_router: response expectations are queued when
// a port response is driven and popped when the core side is sampled.
module tb_ycr_dmem_router;

    localparam logic [1:0] NOTRDY = 2'b00;
    localparam logic [1:0] OK     = 2'b01;
    localparam logic [1:0] LOK    = 2'b11;
    localparam logic       RD     = 1'b0;
    localparam logic       WR     = 1'b1;

    logic        core_clk = 1'b0;
    logic        core_rst_n;
    logic        dmem_req, dmem_req_ack, dmem_cmd;
    logic [1:0]  dmem_width, dmem_resp;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [9:0]  dmem_bl;
    logic        p0_req, p0_req_ack, p0_cmd, p1_req, p1_req_ack, p1_cmd;
    logic [1:0]  p0_width, p0_resp, p1_width, p1_resp;
    logic [31:0] p0_addr, p0_wdata, p0_rdata, p1_addr, p1_wdata, p1_rdata;
    logic [9:0]  p0_bl, p1_bl;
    logic        spurious_resp;

    int n_total = 0;
    int n_bad   = 0;
    logic [33:0] sb[$];
    logic [33:0] got, exp;

    always #5 core_clk = ~core_clk;

    ycr_dmem_router #(.MAX_OUTST(2), .BL_W(10)) dut (
        .core_clk(core_clk), .core_rst_n(core_rst_n),
        .dmem_req(dmem_req), .dmem_req_ack(dmem_req_ack), .dmem_cmd(dmem_cmd),
        .dmem_width(dmem_width), .dmem_addr(dmem_addr), .dmem_bl(dmem_bl),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
        .p0_req(p0_req), .p0_req_ack(p0_req_ack), .p0_cmd(p0_cmd), .p0_width(p0_width),
        .p0_addr(p0_addr), .p0_bl(p0_bl), .p0_wdata(p0_wdata), .p0_rdata(p0_rdata),
        .p0_resp(p0_resp),
        .p1_req(p1_req), .p1_req_ack(p1_req_ack), .p1_cmd(p1_cmd), .p1_width(p1_width),
        .p1_addr(p1_addr), .p1_bl(p1_bl), .p1_wdata(p1_wdata), .p1_rdata(p1_rdata),
        .p1_resp(p1_resp),
        .spurious_resp(spurious_resp)
    );

    // Issue one core request to the given port and complete the handshake.
    // lat = cycles from dmem_req to port req (-1 on timeout).
    task automatic do_req(input logic port, input logic [31:0] addr, input logic cmd,
                          input logic [9:0] bl, input logic [31:0] wd,
                          output int lat, output logic ack_seen,
                          output logic [9:0] bl_seen, output logic [31:0] wd_seen);
        lat = -1; ack_seen = 1'b0; bl_seen = '0; wd_seen = '0;
        @(negedge core_clk);
        dmem_req = 1'b1; dmem_addr = addr; dmem_cmd = cmd; dmem_bl = bl;
        dmem_wdata = wd; dmem_width = 2'b10;
        for (int k = 1; k <= 20; k++) begin
            @(negedge core_clk); #1;
            if (port ? p1_req : p0_req) begin lat = k; break; end
        end
        if (lat > 0) begin
            bl_seen = port ? p1_bl : p0_bl;
            wd_seen = port ? p1_wdata : p0_wdata;
            if (port) p1_req_ack = 1'b1; else p0_req_ack = 1'b1;
            #1 ack_seen = dmem_req_ack;
            @(negedge core_clk);
        end
        dmem_req = 1'b0; p0_req_ack = 1'b0; p1_req_ack = 1'b0;
    endtask

    // Drive one response beat on a port and queue what the core should see.
    task automatic drive_resp(input logic port, input logic [1:0] resp,
                              input logic [31:0] data, input logic fwd);
        @(negedge core_clk);
        if (port) begin p1_resp = resp; p1_rdata = data; end
        else      begin p0_resp = resp; p0_rdata = data; end
        sb.push_back(fwd ? {resp, data} : {NOTRDY, 32'h0});
        #1;
    endtask

    task automatic clr_resp();
        @(negedge core_clk);
        p0_resp = NOTRDY; p1_resp = NOTRDY; p0_rdata = '0; p1_rdata = '0;
        #1;
    endtask

    task automatic test_reset();
        core_rst_n = 1'b0;
        dmem_req = 0; dmem_cmd = RD; dmem_width = 0; dmem_addr = 0; dmem_bl = 0;
        dmem_wdata = 0; p0_req_ack = 0; p1_req_ack = 0;
        p0_resp = NOTRDY; p1_resp = NOTRDY; p0_rdata = 0; p1_rdata = 0;
        repeat (2) @(negedge core_clk);
        #1;
        n_total++;
        if ({dmem_req_ack, p0_req, p1_req, dmem_resp, dmem_rdata, spurious_resp} !== 38'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: ack=%b p0=%b p1=%b resp=%h rdata=%h spur=%b want all 0",
                     dmem_req_ack, p0_req, p1_req, dmem_resp, dmem_rdata, spurious_resp);
        end
        @(negedge core_clk) core_rst_n = 1'b1;
    endtask

    task automatic test_single_read_p1();
        int lat; logic ack; logic [9:0] bl; logic [31:0] wd;
        do_req(1'b1, 32'h0000_1000, RD, 10'd1, 32'h0, lat, ack, bl, wd);
        n_total++;
        if (lat !== 1) begin n_bad++; $display("FAIL p1_latency: got %0d want 1", lat); end
        n_total++;
        if (ack !== 1'b1) begin n_bad++; $display("FAIL p1_core_ack: got %b want 1", ack); end
        drive_resp(1'b1, LOK, 32'hDEAD_BEEF, 1'b1);
        got = {dmem_resp, dmem_rdata}; exp = sb.pop_front(); n_total++;
        if (got !== exp) begin n_bad++; $display("FAIL p1_read_resp: got %h want %h", got, exp); end
        clr_resp();
        n_total++;
        if (dmem_resp !== NOTRDY) begin n_bad++; $display("FAIL p1_after_pop: got %h want %h", dmem_resp, NOTRDY); end
    endtask

    task automatic test_p0_write();
        int lat; logic ack; logic [9:0] bl; logic [31:0] wd;
        do_req(1'b0, 32'h0C48_0010, WR, 10'd4, 32'h5A5A_1234, lat, ack, bl, wd);
        n_total++;
        if (lat !== 1) begin n_bad++; $display("FAIL p0_latency: got %0d want 1 (empty fifo)", lat); end
        n_total++;
        if (bl !== 10'd1) begin n_bad++; $display("FAIL p0_bl_forced: got %0d want 1", bl); end
        n_total++;
        if (wd !== 32'h5A5A_1234) begin n_bad++; $display("FAIL p0_wdata: got %h want 5a5a1234", wd); end
        drive_resp(1'b0, OK, 32'h0, 1'b1);
        got = {dmem_resp, dmem_rdata}; exp = sb.pop_front(); n_total++;
        if (got !== exp) begin n_bad++; $display("FAIL p0_write_resp: got %h want %h", got, exp); end
        clr_resp();
        n_total++;
        if (spurious_resp !== 1'b0) begin n_bad++; $display("FAIL p0_no_spurious: got %b want 0", spurious_resp); end
    endtask

    task automatic test_port_switch_block();
        int lat; logic ack; logic [9:0] bl; logic [31:0] wd;
        do_req(1'b1, 32'h0000_2000, RD, 10'd1, 32'h0, lat, ack, bl, wd);
        dmem_req = 1'b1; dmem_addr = 32'h0C48_0020; dmem_cmd = RD; dmem_bl = 10'd1;
        for (int k = 0; k < 3; k++) begin
            @(negedge core_clk); #1;
            n_total++;
            if (p0_req !== 1'b0 || p1_req !== 1'b0) begin
                n_bad++; $display("FAIL switch_blocked[%0d]: p0=%b p1=%b want 0 0", k, p0_req, p1_req);
            end
        end
        drive_resp(1'b1, LOK, 32'h1111_2222, 1'b1);
        got = {dmem_resp, dmem_rdata}; exp = sb.pop_front(); n_total++;
        if (got !== exp) begin n_bad++; $display("FAIL switch_p1_resp: got %h want %h", got, exp); end
        clr_resp();
        n_total++;
        if (p0_req !== 1'b0) begin n_bad++; $display("FAIL switch_pop_cycle: p0_req=%b want 0", p0_req); end
        @(negedge core_clk); #1;
        n_total++;
        if (p0_req !== 1'b1) begin n_bad++; $display("FAIL switch_grant: p0_req=%b want 1", p0_req); end
        p0_req_ack = 1'b1;
        @(negedge core_clk);
        dmem_req = 1'b0; p0_req_ack = 1'b0;
        drive_resp(1'b0, OK, 32'h3333_4444, 1'b1);
        got = {dmem_resp, dmem_rdata}; exp = sb.pop_front(); n_total++;
        if (got !== exp) begin n_bad++; $display("FAIL switch_p0_resp: got %h want %h", got, exp); end
        clr_resp();
    endtask

    task automatic test_outstanding_burst();
        int lat; logic ack; logic [9:0] bl; logic [31:0] wd;
        do_req(1'b1, 32'h0000_3000, RD, 10'd4, 32'h0, lat, ack, bl, wd);
        n_total++;
        if (bl !== 10'd4) begin n_bad++; $display("FAIL burst_bl: got %0d want 4", bl); end
        do_req(1'b1, 32'h0000_4000, RD, 10'd1, 32'h0, lat, ack, bl, wd);
        n_total++;
        if (lat !== 1) begin n_bad++; $display("FAIL second_outst_lat: got %0d want 1", lat); end
        dmem_req = 1'b1; dmem_addr = 32'h0000_5000; dmem_bl = 10'd1;
        for (int k = 0; k < 2; k++) begin
            @(negedge core_clk); #1;
            n_total++;
            if (p1_req !== 1'b0) begin n_bad++; $display("FAIL full_hold[%0d]: p1_req=%b want 0", k, p1_req); end
        end
        for (int b = 0; b < 4; b++) begin
            drive_resp(1'b1, (b == 3) ? LOK : OK, 32'hA000_0000 + b, 1'b1);
            got = {dmem_resp, dmem_rdata}; exp = sb.pop_front(); n_total++;
            if (got !== exp) begin n_bad++; $display("FAIL burst_beat%0d: got %h want %h", b, got, exp); end
            n_total++;
            if (p1_req !== 1'b0) begin n_bad++; $display("FAIL burst_hold%0d: p1_req=%b want 0", b, p1_req); end
        end
        clr_resp();
        n_total++;
        if (p1_req !== 1'b0) begin n_bad++; $display("FAIL burst_pop_cycle: p1_req=%b want 0", p1_req); end
        @(negedge core_clk); #1;
        n_total++;
        if (p1_req !== 1'b1) begin n_bad++; $display("FAIL third_grant: p1_req=%b want 1", p1_req); end
        p1_req_ack = 1'b1;
        @(negedge core_clk);
        dmem_req = 1'b0; p1_req_ack = 1'b0;
        for (int t = 0; t < 2; t++) begin
            drive_resp(1'b1, LOK, 32'hB000_0000 + t, 1'b1);
            got = {dmem_resp, dmem_rdata}; exp = sb.pop_front(); n_total++;
            if (got !== exp) begin n_bad++; $display("FAIL drain%0d: got %h want %h", t, got, exp); end
            clr_resp();
        end
    endtask

    task automatic test_spurious();
        drive_resp(1'b0, OK, 32'h0000_1234, 1'b0);
        got = {dmem_resp, dmem_rdata}; exp = sb.pop_front(); n_total++;
        if (got !== exp) begin n_bad++; $display("FAIL spur_dropped: got %h want %h", got, exp); end
        clr_resp();
        n_total++;
        if (spurious_resp !== 1'b1) begin n_bad++; $display("FAIL spur_set: got %b want 1", spurious_resp); end
        repeat (3) @(negedge core_clk);
        #1;
        n_total++;
        if (spurious_resp !== 1'b1) begin n_bad++; $display("FAIL spur_sticky: got %b want 1", spurious_resp); end
    endtask

    task automatic test_reset_midflight();
        int lat; logic ack; logic [9:0] bl; logic [31:0] wd;
        do_req(1'b1, 32'h0000_6000, RD, 10'd1, 32'h0, lat, ack, bl, wd);
        do_req(1'b1, 32'h0000_7000, RD, 10'd1, 32'h0, lat, ack, bl, wd);
        @(negedge core_clk);
        core_rst_n = 1'b0; p1_resp = LOK; p1_rdata = 32'hCAFE_F00D;
        #1;
        n_total++;
        if ({dmem_req_ack, p0_req, p1_req, dmem_resp, dmem_rdata, spurious_resp} !== 38'h0) begin
            n_bad++;
            $display("FAIL midreset_outputs: ack=%b p0=%b p1=%b resp=%h rdata=%h spur=%b want all 0",
                     dmem_req_ack, p0_req, p1_req, dmem_resp, dmem_rdata, spurious_resp);
        end
        @(negedge core_clk);
        p1_resp = NOTRDY; p1_rdata = 0;
        @(negedge core_clk) core_rst_n = 1'b1;
        // An empty FIFO lets a port-0 request through immediately.
        do_req(1'b0, 32'h0C48_0040, RD, 10'd1, 32'h0, lat, ack, bl, wd);
        n_total++;
        if (lat !== 1) begin n_bad++; $display("FAIL postreset_empty: p0 lat got %0d want 1", lat); end
        drive_resp(1'b0, OK, 32'h7777_0000, 1'b1);
        got = {dmem_resp, dmem_rdata}; exp = sb.pop_front(); n_total++;
        if (got !== exp) begin n_bad++; $display("FAIL postreset_p0_resp: got %h want %h", got, exp); end
        clr_resp();
        drive_resp(1'b1, LOK, 32'h8888_0000, 1'b0);
        got = {dmem_resp, dmem_rdata}; exp = sb.pop_front(); n_total++;
        if (got !== exp) begin n_bad++; $display("FAIL stale_resp_dropped: got %h want %h", got, exp); end
        clr_resp();
        n_total++;
        if (spurious_resp !== 1'b1) begin n_bad++; $display("FAIL stale_resp_spur: got %b want 1", spurious_resp); end
    endtask

    initial begin
        test_reset();
        test_single_read_p1();
        test_p0_write();
        test_port_switch_block();
        test_outstanding_burst();
        test_spurious();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
